// File: rtl/frost32_mem_bridge_pkg.sv
// Shared types for the Frost32 memory bridge.
//   diat_t          CPU access type (read / write)
//   dias_t          CPU access size (32 / 16 / 8 bit, or the invalid encoding)
//   bridge_state_t  bridge FSM states
//   mem_bus_req_t   fields presented on the valid/ready memory bus
//   cpu_req_t       unpacked view of the 68-bit CPU request port
//                   {data[31:0], addr[31:0], access_type, access_size[1:0], req_mem_access}
package frost32_mem_bridge_pkg;

    typedef enum logic {
        DiatRead  = 1'b0,
        DiatWrite = 1'b1
    } diat_t;

    typedef enum logic [1:0] {
        Dias32  = 2'd0,
        Dias16  = 2'd1,
        Dias8   = 2'd2,
        DiasBad = 2'd3
    } dias_t;

    localparam int MSB_POS__FROST32_BRIDGE_STATE = 1;

    typedef enum logic [MSB_POS__FROST32_BRIDGE_STATE:0] {
        StBrIdle     = 2'd0,
        StBrIssue    = 2'd1,
        StBrWaitResp = 2'd2,
        StBrAck      = 2'd3
    } bridge_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  byte_en;
    } mem_bus_req_t;

    // First member lands in the MSBs of the 68-bit port.
    typedef struct packed {
        logic [31:0] data;
        logic [31:0] addr;
        diat_t       access_type;
        dias_t       access_size;
        logic        req_mem_access;
    } cpu_req_t;

endpackage

// File: rtl/frost32_lane_steer.sv
// Combinational byte-lane steering for the Frost32 memory bridge.
//   size_i        access size
//   addr_lo_i     byte offset within the word (addr[1:0])
//   wdata_i       CPU write data, right-aligned
//   rdata_i       bus read word
//   byte_en_o     active lanes, lane 0 = bits 7:0
//   wdata_o       write data replicated across all lanes of its size
//   rdata_o       selected byte/halfword shifted to bit 0, zero-extended
//   misalign_o    access is illegal (misaligned or invalid size)
module frost32_lane_steer
    import frost32_mem_bridge_pkg::*;
(
    input  dias_t       size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  byte_en_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [31:0] rdata_shifted;

    assign rdata_shifted = rdata_i >> {addr_lo_i, 3'b000};

    always_comb begin
        byte_en_o  = 4'b0000;
        wdata_o    = wdata_i;
        rdata_o    = rdata_i;
        misalign_o = 1'b0;
        case (size_i)
            Dias32: begin
                byte_en_o  = 4'b1111;
                misalign_o = (addr_lo_i != 2'b00);
            end
            Dias16: begin
                byte_en_o  = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o    = {2{wdata_i[15:0]}};
                rdata_o    = {16'h0000, rdata_shifted[15:0]};
                misalign_o = addr_lo_i[0];
            end
            Dias8: begin
                byte_en_o  = 4'b0001 << addr_lo_i;
                wdata_o    = {4{wdata_i[7:0]}};
                rdata_o    = {24'h000000, rdata_shifted[7:0]};
            end
            DiasBad: begin
                misalign_o = 1'b1;
            end
            default: begin
                misalign_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/frost32_mem_bridge.sv
// Bridge from the Frost32 CPU memory-request port to a valid/ready word bus.
//   clk, rst_n          clock, asynchronous active-low reset
//   in_cpu              68-bit CPU request {data, addr, type, size, req_mem_access}
//   out_cpu             last successful read data, right-aligned, zero-extended
//   out_cpu_ack         one-cycle completion pulse
//   out_cpu_err         qualifies out_cpu_ack: misaligned, invalid size or timeout
//   out_bus_*           word-aligned bus request (valid, addr, we, wdata, byte_en)
//   in_bus_req_ready    bus accepts the request when high with valid
//   in_bus_resp_valid   single-cycle read response strobe with in_bus_rdata
//
// state        | meaning
// StBrIdle     | sampling req_mem_access, capturing the request
// StBrIssue    | bus request valid, waiting for ready
// StBrWaitResp | read accepted, waiting for the response
// StBrAck      | one-cycle ack (and err) back to the CPU
module frost32_mem_bridge
    import frost32_mem_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [67:0] in_cpu,
    output logic [31:0] out_cpu,
    output logic        out_cpu_ack,
    output logic        out_cpu_err,
    output logic        out_bus_req_valid,
    input  logic        in_bus_req_ready,
    output logic [31:0] out_bus_addr,
    output logic        out_bus_we,
    output logic [31:0] out_bus_wdata,
    output logic [3:0]  out_bus_byte_en,
    input  logic        in_bus_resp_valid,
    input  logic [31:0] in_bus_rdata
);

    cpu_req_t       cpu_req;
    bridge_state_t  state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    mem_bus_req_t   bus_q;
    logic           valid_q;
    logic           ack_q;
    logic           err_q;
    logic [31:0]    rdata_q;
    dias_t          cap_size_q;
    logic [1:0]     cap_addr_lo_q;

    dias_t          steer_size;
    logic [1:0]     steer_addr_lo;
    logic [3:0]     steer_byte_en;
    logic [31:0]    steer_wdata;
    logic [31:0]    steer_rdata;
    logic           steer_misalign;
    logic           timeout;

    assign cpu_req = cpu_req_t'(in_cpu);

    // One steering instance serves both directions: in Idle it looks at the
    // incoming request (lanes, wdata, legality); afterwards it looks at the
    // captured request so the read response can be extracted.
    assign steer_size    = (state_q == StBrIdle) ? cpu_req.access_size : cap_size_q;
    assign steer_addr_lo = (state_q == StBrIdle) ? cpu_req.addr[1:0] : cap_addr_lo_q;

    frost32_lane_steer u_lane_steer (
        .size_i     (steer_size),
        .addr_lo_i  (steer_addr_lo),
        .wdata_i    (cpu_req.data),
        .rdata_i    (in_bus_rdata),
        .byte_en_o  (steer_byte_en),
        .wdata_o    (steer_wdata),
        .rdata_o    (steer_rdata),
        .misalign_o (steer_misalign)
    );

    assign timeout = (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StBrIdle;
            cnt_q         <= '0;
            bus_q         <= '0;
            valid_q       <= 1'b0;
            ack_q         <= 1'b0;
            err_q         <= 1'b0;
            rdata_q       <= '0;
            cap_size_q    <= Dias32;
            cap_addr_lo_q <= 2'b00;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                StBrIdle: begin
                    if (cpu_req.req_mem_access) begin
                        cap_size_q    <= cpu_req.access_size;
                        cap_addr_lo_q <= cpu_req.addr[1:0];
                        if (steer_misalign) begin
                            state_q <= StBrAck;
                            ack_q   <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            bus_q.addr    <= {cpu_req.addr[31:2], 2'b00};
                            bus_q.we      <= (cpu_req.access_type == DiatWrite);
                            bus_q.wdata   <= steer_wdata;
                            bus_q.byte_en <= steer_byte_en;
                            valid_q       <= 1'b1;
                            cnt_q         <= '0;
                            state_q       <= StBrIssue;
                        end
                    end
                end
                StBrIssue: begin
                    cnt_q <= cnt_q + CNT_WIDTH'(1);
                    // Handshake takes priority over a coincident timeout.
                    if (in_bus_req_ready) begin
                        valid_q <= 1'b0;
                        if (bus_q.we) begin
                            state_q <= StBrAck;
                            ack_q   <= 1'b1;
                        end else begin
                            state_q <= StBrWaitResp;
                        end
                    end else if (timeout) begin
                        valid_q <= 1'b0;
                        state_q <= StBrAck;
                        ack_q   <= 1'b1;
                        err_q   <= 1'b1;
                    end
                end
                StBrWaitResp: begin
                    cnt_q <= cnt_q + CNT_WIDTH'(1);
                    if (in_bus_resp_valid) begin
                        rdata_q <= steer_rdata;
                        state_q <= StBrAck;
                        ack_q   <= 1'b1;
                    end else if (timeout) begin
                        state_q <= StBrAck;
                        ack_q   <= 1'b1;
                        err_q   <= 1'b1;
                    end
                end
                StBrAck: begin
                    state_q <= StBrIdle;
                end
                default: begin
                    state_q <= StBrIdle;
                end
            endcase
        end
    end

    assign out_cpu           = rdata_q;
    assign out_cpu_ack       = ack_q;
    assign out_cpu_err       = err_q;
    assign out_bus_req_valid = valid_q;
    assign out_bus_addr      = bus_q.addr;
    assign out_bus_we        = bus_q.we;
    assign out_bus_wdata     = bus_q.wdata;
    assign out_bus_byte_en   = bus_q.byte_en;

endmodule

// File: doc/frost32_mem_bridge.md
Name: frost32_mem_bridge

Overview:
- Downstream neighbour of the Frost32 CPU core.
- Consumes the CPU's memory-request port: data, addr, access type, access size, req_mem_access.
- Turns each request into a single word-aligned transaction on a valid/ready memory bus, with byte enables.
- Returns lane-extracted read data plus a one-cycle ack/err pulse; the CPU's StMemAccess stall waits on this pulse.

Parameters:
- TIMEOUT_CYCLES, 255: number of cycles in StBrIssue+StBrWaitResp before the request is aborted with err. Must be ≥2.
- CNT_WIDTH, 8: width of the timeout counter. Must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_cpu  in  68  PortOut_Frost32Cpu: data[31:0], addr[31:0], data_inout_access_type (0=DiatRead, 1=DiatWrite), data_inout_access_size[1:0], req_mem_access
- out_cpu  out  32  PortIn_Frost32Cpu: read data, right-aligned, zero-extended
- out_cpu_ack  out  1  request complete, one-cycle pulse
- out_cpu_err  out  1  qualifies out_cpu_ack: misaligned access, DiasBad, or timeout
- out_bus_req_valid  out  1  bus request valid
- in_bus_req_ready  in  1  bus accepts the request when high together with valid
- out_bus_addr  out  32  word address, bits [1:0] always 0
- out_bus_we  out  1  1 = write
- out_bus_wdata  out  32  write data, replicated across lanes
- out_bus_byte_en  out  4  active lanes, little-endian (lane 0 = bits 7:0)
- in_bus_resp_valid  in  1  read data valid, single-cycle
- in_bus_rdata  in  32  read word

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=StBrIdle, counter=0.
  - All outputs 0, including out_cpu and out_bus_byte_en.
  - Reset asserted mid-transaction aborts it silently: no ack.
- StBrIdle:
  - req_mem_access is sampled each cycle. On a sampled request, addr/type/size/data are captured into internal registers.
  - A request is illegal when: size=Dias32 with addr[1:0]≠0; size=Dias16 with addr[0]≠0; or size=DiasBad.
  - Illegal request → StBrAck with err=1, no bus activity. Ack appears the cycle after sampling.
  - Legal request → StBrIssue, counter cleared.
- StBrIssue:
  - out_bus_req_valid=1; addr/we/wdata/byte_en are stable from the captured registers.
  - On ready, a write → StBrAck (posted write).
  - On ready, a read → StBrWaitResp.
  - out_bus_req_valid drops the cycle after acceptance.
- StBrWaitResp:
  - On in_bus_resp_valid: extract the lane, load out_cpu → StBrAck.
  - The bus never gives a response in its accept cycle. in_bus_resp_valid seen outside StBrWaitResp is ignored.
- StBrAck:
  - out_cpu_ack=1 for exactly one cycle, then → StBrIdle.
  - out_cpu_err is high only in this cycle, and only on an error.
  - CPU contract: req_mem_access is low in the cycle after ack, unless the CPU intends a new request. A request that is still high is taken as new.
- Timeout:
  - The counter increments every cycle in StBrIssue or StBrWaitResp.
  - When counter==TIMEOUT_CYCLES-1 and the pending handshake has not completed that cycle: drop valid → StBrAck with err=1.
  - out_cpu keeps its old value on timeout.
  - If a handshake and the timeout land in the same cycle, the handshake wins.
- Lane steering:
  - Dias32: byte_en=1111.
  - Dias16: byte_en=0011 at addr[1]=0, 1100 at addr[1]=1.
  - Dias8: byte_en=0001<<addr[1:0].
  - wdata: Dias8 → byte replicated ×4; Dias16 → halfword ×2; Dias32 → as-is.
  - Read data: the selected byte/halfword is shifted to bit 0 and zero-extended; sign extension is the CPU's job.
- out_cpu holds the last successful read value. Writes and errors leave it unchanged.
- Minimum latency:
  - Read: 3 cycles from sample to ack (issue, resp, ack) when ready and resp each take 0 wait.
  - Write: 2 cycles.
  - Error: 1 cycle.

Decomposition:
- Additions to PkgFrost32Cpu:
  - BridgeState enum {StBrIdle, StBrIssue, StBrWaitResp, StBrAck}
  - struct MemBusReq {addr, we, wdata, byte_en}
  - define MSB_POS__FROST32_BRIDGE_STATE
- One combinational sub-module, frost32_lane_steer: inputs are size, addr[1:0], wdata, rdata; outputs are byte_en, replicated wdata, extracted rdata, and misalign flag.
- The bridge owns the FSM, capture registers and timeout counter.

Test Plan:
- Dias32 read addr=0x100, ready immediate, resp one cycle later with rdata=0xDEADBEEF → bus addr=0x100, byte_en=1111, we=0; ack 3 cycles after sample; out_cpu=0xDEADBEEF; err=0.
- Dias8 write addr=0x203 data=0x000000A5, ready held low 4 cycles → valid stays high with stable fields; byte_en=1000, wdata=0xA5A5A5A5; ack the cycle after acceptance.
- Dias16 read addr=0x102, rdata=0x1234ABCD → byte_en=1100; out_cpu=0x00001234.
- Dias32 read addr=0x101, then DiasBad read → each gives ack+err one cycle after sample; out_bus_req_valid never rises; out_cpu unchanged.
- TIMEOUT_CYCLES=8, read accepted, no resp → ack+err exactly 8 cycles after entering StBrIssue. A resp_valid injected 2 cycles later is ignored; the next request completes normally.
- rst_n pulsed low asynchronously, mid-clock, while in StBrWaitResp → all outputs 0 immediately, no ack ever emitted. After release, a Dias32 read completes normally.
